csr_file: RTL

Control/status register file answering the CSR access and exception-commit requests issued by the WB stage. It returns read data combinationally for `csr_rvalue`, applies masked software writes, and records exception entry (`wb_ex`) and return (`ertn_flush`). It also runs the stable-counter timer and provides the redirect targets `ex_entry` and `ertn_entry` to the fetch stage. It sits beside the register file and receives its request signals straight from WB.

---
 rtl/csr_file_if.sv | 35 +++
 rtl/csr_file.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_if.sv
// CSR access / exception-commit bundle between the WB stage and csr_file.
//   master : WB side, drives requests and receives read data / redirect targets
//   slave  : csr_file side
// Signals:
//   csr_re, csr_num[13:0], csr_we, csr_wmask[31:0], csr_wvalue[31:0]  - CSR access
//   ertn_flush, wb_ex, wb_ecode[5:0], wb_esubcode[8:0], wb_pc[31:0]   - commit events
//   csr_rvalue[31:0], ex_entry[31:0], ertn_entry[31:0], has_int       - responses
interface csr_file_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn_flush;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] csr_rvalue;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        output ertn_flush, wb_ex, wb_ecode, wb_esubcode, wb_pc,
        input  csr_rvalue, ex_entry, ertn_entry, has_int
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        input  ertn_flush, wb_ex, wb_ecode, wb_esubcode, wb_pc,
        output csr_rvalue, ex_entry, ertn_entry, has_int
    );
endinterface

// File: rtl/csr_file.sv
// Control/status register file serving CSR reads/writes and exception commit from WB.
// Reads are combinational; writes, exception entry, ERTN and the stable timer update
// on the rising clock edge.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   bus  - csr_file_if.slave: CSR access, commit events, read data, redirect targets
//          (ex_entry = EENTRY, ertn_entry = ERA) and the has_int interrupt summary.
module csr_file (
    input logic       clk,
    input logic       rst,
    csr_file_if.slave bus
);
    localparam logic [13:0] CsrCrmd   = 14'h000;
    localparam logic [13:0] CsrPrmd   = 14'h001;
    localparam logic [13:0] CsrEcfg   = 14'h004;
    localparam logic [13:0] CsrEstat  = 14'h005;
    localparam logic [13:0] CsrEra    = 14'h006;
    localparam logic [13:0] CsrEentry = 14'h00C;
    localparam logic [13:0] CsrSave0  = 14'h030;
    localparam logic [13:0] CsrSave1  = 14'h031;
    localparam logic [13:0] CsrSave2  = 14'h032;
    localparam logic [13:0] CsrSave3  = 14'h033;
    localparam logic [13:0] CsrTid    = 14'h040;
    localparam logic [13:0] CsrTcfg   = 14'h041;
    localparam logic [13:0] CsrTval   = 14'h042;
    localparam logic [13:0] CsrTiclr  = 14'h044;

    // State
    logic [1:0]  crmd_plv_q, crmd_plv_d;
    logic        crmd_ie_q, crmd_ie_d;
    logic        crmd_da_q, crmd_da_d;
    logic [1:0]  prmd_pplv_q, prmd_pplv_d;
    logic        prmd_pie_q, prmd_pie_d;
    logic [12:0] ecfg_lie_q, ecfg_lie_d;
    logic [1:0]  estat_is_sw_q, estat_is_sw_d;
    logic        estat_ti_q, estat_ti_d;
    logic [5:0]  estat_ecode_q, estat_ecode_d;
    logic [8:0]  estat_esubcode_q, estat_esubcode_d;
    logic [31:0] era_q, era_d;
    logic [25:0] eentry_va_q, eentry_va_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [31:0] tid_q, tid_d;
    logic        tcfg_en_q, tcfg_en_d;
    logic        tcfg_periodic_q, tcfg_periodic_d;
    logic [29:0] tcfg_initval_q, tcfg_initval_d;
    logic [31:0] tval_q, tval_d;

    // Architectural read views of each register
    logic [12:0] estat_is;
    logic [31:0] crmd_val, prmd_val, ecfg_val, estat_val, eentry_val, tcfg_val;

    assign estat_is   = {1'b0, estat_ti_q, 9'd0, estat_is_sw_q};
    assign crmd_val   = {28'd0, crmd_da_q, crmd_ie_q, crmd_plv_q};
    assign prmd_val   = {29'd0, prmd_pie_q, prmd_pplv_q};
    assign ecfg_val   = {19'd0, ecfg_lie_q};
    assign estat_val  = {1'b0, estat_esubcode_q, estat_ecode_q, 3'd0, estat_is};
    assign eentry_val = {eentry_va_q, 6'd0};
    assign tcfg_val   = {tcfg_initval_q, tcfg_periodic_q, tcfg_en_q};

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Software write decode; an exception in the same cycle squashes the write
    logic sw_we;
    logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_eentry;
    logic wr_save, wr_tid, wr_tcfg, wr_ticlr;

    assign sw_we     = bus.csr_we & ~bus.wb_ex;
    assign wr_crmd   = sw_we && (bus.csr_num == CsrCrmd);
    assign wr_prmd   = sw_we && (bus.csr_num == CsrPrmd);
    assign wr_ecfg   = sw_we && (bus.csr_num == CsrEcfg);
    assign wr_estat  = sw_we && (bus.csr_num == CsrEstat);
    assign wr_era    = sw_we && (bus.csr_num == CsrEra);
    assign wr_eentry = sw_we && (bus.csr_num == CsrEentry);
    assign wr_save   = sw_we && (bus.csr_num[13:2] == CsrSave0[13:2]);
    assign wr_tid    = sw_we && (bus.csr_num == CsrTid);
    assign wr_tcfg   = sw_we && (bus.csr_num == CsrTcfg);
    assign wr_ticlr  = sw_we && (bus.csr_num == CsrTiclr);

    // Merged write values per register
    logic [31:0] crmd_wr, prmd_wr, ecfg_wr, estat_wr, era_wr, eentry_wr;
    logic [31:0] save_wr, tid_wr, tcfg_wr;

    assign crmd_wr   = merge(crmd_val, bus.csr_wvalue, bus.csr_wmask);
    assign prmd_wr   = merge(prmd_val, bus.csr_wvalue, bus.csr_wmask);
    assign ecfg_wr   = merge(ecfg_val, bus.csr_wvalue, bus.csr_wmask);
    assign estat_wr  = merge(estat_val, bus.csr_wvalue, bus.csr_wmask);
    assign era_wr    = merge(era_q, bus.csr_wvalue, bus.csr_wmask);
    assign eentry_wr = merge(eentry_val, bus.csr_wvalue, bus.csr_wmask);
    assign save_wr   = merge(save_q[bus.csr_num[1:0]], bus.csr_wvalue, bus.csr_wmask);
    assign tid_wr    = merge(tid_q, bus.csr_wvalue, bus.csr_wmask);
    assign tcfg_wr   = merge(tcfg_val, bus.csr_wvalue, bus.csr_wmask);

    // Timer events. A TCFG write reloads TVAL and suppresses countdown for that cycle.
    logic timer_fire;
    logic ticlr_clr;

    assign timer_fire = ~wr_tcfg & tcfg_en_q & (tval_q == 32'd1);
    assign ticlr_clr  = wr_ticlr & bus.csr_wmask[0] & bus.csr_wvalue[0];

    always_comb begin
        crmd_plv_d       = crmd_plv_q;
        crmd_ie_d        = crmd_ie_q;
        crmd_da_d        = crmd_da_q;
        prmd_pplv_d      = prmd_pplv_q;
        prmd_pie_d       = prmd_pie_q;
        ecfg_lie_d       = ecfg_lie_q;
        estat_is_sw_d    = estat_is_sw_q;
        estat_ti_d       = estat_ti_q;
        estat_ecode_d    = estat_ecode_q;
        estat_esubcode_d = estat_esubcode_q;
        era_d            = era_q;
        eentry_va_d      = eentry_va_q;
        for (int i = 0; i < 4; i++) begin
            save_d[i] = save_q[i];
        end
        tid_d            = tid_q;
        tcfg_en_d        = tcfg_en_q;
        tcfg_periodic_d  = tcfg_periodic_q;
        tcfg_initval_d   = tcfg_initval_q;
        tval_d           = tval_q;

        // Software writes (lowest precedence)
        if (wr_crmd) begin
            crmd_plv_d = crmd_wr[1:0];
            crmd_ie_d  = crmd_wr[2];
            crmd_da_d  = crmd_wr[3];
        end
        if (wr_prmd) begin
            prmd_pplv_d = prmd_wr[1:0];
            prmd_pie_d  = prmd_wr[2];
        end
        if (wr_ecfg) begin
            ecfg_lie_d = ecfg_wr[12:0];
        end
        if (wr_estat) begin
            estat_is_sw_d = estat_wr[1:0];
        end
        if (wr_era) begin
            era_d = era_wr;
        end
        if (wr_eentry) begin
            eentry_va_d = eentry_wr[31:6];
        end
        if (wr_save) begin
            save_d[bus.csr_num[1:0]] = save_wr;
        end
        if (wr_tid) begin
            tid_d = tid_wr;
        end
        if (wr_tcfg) begin
            tcfg_en_d       = tcfg_wr[0];
            tcfg_periodic_d = tcfg_wr[1];
            tcfg_initval_d  = tcfg_wr[31:2];
        end

        // ERTN restores PLV/IE, overriding a same-cycle CRMD write to those fields
        if (bus.ertn_flush && !bus.wb_ex) begin
            crmd_plv_d = prmd_pplv_q;
            crmd_ie_d  = prmd_pie_q;
        end

        // Exception entry (highest precedence; all software writes already squashed)
        if (bus.wb_ex) begin
            prmd_pplv_d      = crmd_plv_q;
            prmd_pie_d       = crmd_ie_q;
            crmd_plv_d       = 2'd0;
            crmd_ie_d        = 1'b0;
            era_d            = bus.wb_pc;
            estat_ecode_d    = bus.wb_ecode;
            estat_esubcode_d = bus.wb_esubcode;
        end

        // Stable timer
        if (wr_tcfg) begin
            tval_d = {tcfg_wr[31:2], 2'b00};
        end else if (tcfg_en_q) begin
            if (tval_q > 32'd1) begin
                tval_d = tval_q - 32'd1;
            end else if (tval_q == 32'd1) begin
                tval_d = tcfg_periodic_q ? {tcfg_initval_q, 2'b00} : 32'd0;
            end
        end

        // A timer expiry in the same cycle as TICLR leaves the interrupt set
        if (timer_fire) begin
            estat_ti_d = 1'b1;
        end else if (ticlr_clr) begin
            estat_ti_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crmd_plv_q       <= 2'd0;
            crmd_ie_q        <= 1'b0;
            crmd_da_q        <= 1'b1;
            prmd_pplv_q      <= 2'd0;
            prmd_pie_q       <= 1'b0;
            ecfg_lie_q       <= 13'd0;
            estat_is_sw_q    <= 2'd0;
            estat_ti_q       <= 1'b0;
            estat_ecode_q    <= 6'd0;
            estat_esubcode_q <= 9'd0;
            era_q            <= 32'd0;
            eentry_va_q      <= 26'd0;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= 32'd0;
            end
            tid_q            <= 32'd0;
            tcfg_en_q        <= 1'b0;
            tcfg_periodic_q  <= 1'b0;
            tcfg_initval_q   <= 30'd0;
            tval_q           <= 32'hFFFF_FFFF;
        end else begin
            crmd_plv_q       <= crmd_plv_d;
            crmd_ie_q        <= crmd_ie_d;
            crmd_da_q        <= crmd_da_d;
            prmd_pplv_q      <= prmd_pplv_d;
            prmd_pie_q       <= prmd_pie_d;
            ecfg_lie_q       <= ecfg_lie_d;
            estat_is_sw_q    <= estat_is_sw_d;
            estat_ti_q       <= estat_ti_d;
            estat_ecode_q    <= estat_ecode_d;
            estat_esubcode_q <= estat_esubcode_d;
            era_q            <= era_d;
            eentry_va_q      <= eentry_va_d;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= save_d[i];
            end
            tid_q            <= tid_d;
            tcfg_en_q        <= tcfg_en_d;
            tcfg_periodic_q  <= tcfg_periodic_d;
            tcfg_initval_q   <= tcfg_initval_d;
            tval_q           <= tval_d;
        end
    end

    // Read mux: unimplemented addresses and TICLR read as zero
    logic [31:0] rvalue;

    always_comb begin
        rvalue = 32'd0;
        case (bus.csr_num)
            CsrCrmd:   rvalue = crmd_val;
            CsrPrmd:   rvalue = prmd_val;
            CsrEcfg:   rvalue = ecfg_val;
            CsrEstat:  rvalue = estat_val;
            CsrEra:    rvalue = era_q;
            CsrEentry: rvalue = eentry_val;
            CsrSave0, CsrSave1, CsrSave2, CsrSave3: rvalue = save_q[bus.csr_num[1:0]];
            CsrTid:    rvalue = tid_q;
            CsrTcfg:   rvalue = tcfg_val;
            CsrTval:   rvalue = tval_q;
            default:   rvalue = 32'd0;
        endcase
    end

    assign bus.csr_rvalue = rvalue;
    assign bus.ex_entry   = eentry_val;
    assign bus.ertn_entry = era_q;
    assign bus.has_int    = crmd_ie_q & (|(estat_is & ecfg_lie_q));

    // csr_re is advisory only; read data is always driven
    logic unused_csr_re;
    assign unused_csr_re = bus.csr_re;
endmodule
